pc_ctrl: RTL
============

// Module: pc_ctrl
// PURPOSE
//  Fetch-sequencing controller for the program counter. Arbitrates the
//  stall, redirect and halt requests from imem, decode and execute, and
//  drives the PC select and stall controls. Also drives the IF/ID squash
//  signal and a saturating stall-cycle performance counter.
//  Sits between the hazard/branch-resolution logic and the PC register.
// PARAMETERS
//  FLUSH_CYC  2   cycles Flush stays high per redirect; 1..7, count includes redirect cycle
//  CNT_W      16  width of StallCnt
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      asynchronous reset, active-high
//  ImemStall  in   1      instruction memory busy; fetch result not valid
//  HazStall   in   1      load-use hazard from decode; hold PC
//  BrTaken    in   1      EX: conditional branch taken, target = PC+2+Imm
//  JmpImm     in   1      EX: PC-relative jump, target = PC+2+Imm
//  JmpReg     in   1      EX: register jump, target = Rs+Imm
//  HaltReq    in   1      halt instruction reached EX
//  PcStall    out  1      hold PC
//  PCSel      out  1      1 = take a redirect target
//  RegJmp     out  1      with PCSel, selects the Rs+Imm target
//  Halt       out  1      PC frozen permanently
//  Flush      out  1      squash IF/ID and ID/EX
//  FetchEn    out  1      imem read enable
//  StallCnt   out  CNT_W  count of PcStall cycles, saturating
// BEHAVIOUR
//  States: RUN, WAIT (imem busy), FLUSH (post-redirect squash), HALTED.
//  Output encodings:
//   - normal increment: PCSel=0, RegJmp=0
//   - Imm redirect: PCSel=1, RegJmp=0
//   - Rs redirect: PCSel=1, RegJmp=1
//   - halt: Halt=1
//  rst asserted: state=RUN, pending redirect cleared, flush count=0, StallCnt=0.
//   While rst is high, all outputs are 0, including FetchEn.
//   From the first cycle after rst releases, FetchEn=1.
//  Priority within a cycle: HaltReq > JmpReg > (BrTaken|JmpImm) > ImemStall > HazStall.
//  Decode is Mealy: redirect and halt controls are asserted in the same cycle as the request.
//  RUN:
//   - HaltReq: Halt=1 and PcStall=1 this cycle; next state HALTED.
//     Any redirect in the same cycle is dropped.
//   - Redirect with ImemStall=0: PCSel/RegJmp asserted this cycle, Flush=1.
//     Next state is FLUSH if FLUSH_CYC>1, otherwise RUN.
//   - Redirect with ImemStall=1: latch the redirect kind into the 2-bit pending register.
//     PcStall=1 and PCSel=0; next state WAIT.
//   - ImemStall alone: PcStall=1; next state WAIT.
//   - HazStall alone: PcStall=1; stay in RUN.
//  WAIT:
//   - PcStall=1 and FetchEn=1 while ImemStall=1.
//   - A new redirect arriving while a redirect is already pending is ignored (first wins).
//   - If nothing is pending, a redirect is latched.
//   - ImemStall drops with a redirect pending: apply it this cycle (PCSel/RegJmp, Flush=1).
//     Clear pending; go to FLUSH or RUN as in RUN.
//   - ImemStall drops with nothing pending: PcStall=HazStall this cycle; next state RUN.
//   - HaltReq: as in RUN, and the pending redirect is discarded.
//  FLUSH:
//   - Flush=1.
//   - The down-counter is loaded with FLUSH_CYC-1 on entry and decrements every cycle,
//     including stalled cycles. Return to RUN after the cycle in which it reaches 1.
//   - Redirects are ignored; they come from squashed instructions.
//   - PcStall=ImemStall|HazStall.
//   - HaltReq is honoured as in RUN.
//  HALTED: Halt=1, PcStall=1, FetchEn=0, Flush=0, PCSel=RegJmp=0. Only rst exits.
//  StallCnt: +1 on each posedge where PcStall=1 and state!=HALTED. Saturates at 2^CNT_W-1.
//  Reset mid-operation (any state) aborts immediately; no pending state survives.
// TESTING
//  1. BrTaken pulse in cycle 5, FLUSH_CYC=2, no stalls:
//     -> c5 PCSel=1, RegJmp=0, Flush=1; c6 PCSel=0, Flush=1; c7 Flush=0.
//  2. ImemStall high c3..c5 with JmpReg pulse in c3:
//     -> c3..c5 PcStall=1, PCSel=0; c6 PCSel=1, RegJmp=1, Flush=1; StallCnt=3.
//  3. HaltReq and BrTaken together in c4:
//     -> c4 Halt=1, PCSel=0; c5..c14 Halt=1, FetchEn=0, StallCnt frozen.
//  4. HazStall high for 2 cycles in RUN:
//     -> PcStall=1 for exactly 2 cycles, Flush=0, StallCnt=2.
//  5. rst pulsed while HALTED, StallCnt=9:
//     -> all outputs 0 during rst; next cycle FetchEn=1, Halt=0, StallCnt=0.
//  6. CNT_W=4, 20 consecutive HazStall cycles -> StallCnt=15, then holds at 15.

Source files
------------

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-sequencing controller arbitrating stall, redirect and halt requests for the PC
module pc_ctrl #(
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ImemStall,
    input  logic             HazStall,
    input  logic             BrTaken,
    input  logic             JmpImm,
    input  logic             JmpReg,
    input  logic             HaltReq,
    output logic             PcStall,
    output logic             PCSel,
    output logic             RegJmp,
    output logic             Halt,
    output logic             Flush,
    output logic             FetchEn,
    output logic [CNT_W-1:0] StallCnt
);
    typedef enum logic [1:0] {RUN, WAIT, FLUSH, HALTED} state_t;
    typedef enum logic [1:0] {P_NONE, P_IMM, P_REG} pend_t;
    localparam logic [2:0] FLOAD = 3'(FLUSH_CYC - 1);
    localparam state_t AFTER = (FLUSH_CYC > 1) ? FLUSH : RUN;
    state_t state_q, state_d;
    pend_t pend_q, pend_d, req_kind, apply;
    logic [2:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic stall, sel, rj, hlt, fl;
    // next-state and Mealy output decode; a latched redirect outranks a newly arriving one
    always_comb begin
        req_kind = JmpReg ? P_REG : (BrTaken | JmpImm) ? P_IMM : P_NONE;
        apply = (pend_q != P_NONE) ? pend_q : req_kind;
        state_d = state_q;
        pend_d = pend_q;
        fcnt_d = fcnt_q;
        stall = 1'b0;
        sel = 1'b0;
        rj = 1'b0;
        hlt = 1'b0;
        fl = 1'b0;
        case (state_q)
            RUN, WAIT: begin
                if (HaltReq) begin
                    hlt = 1'b1;
                    stall = 1'b1;
                    pend_d = P_NONE;
                    state_d = HALTED;
                end else if (ImemStall) begin
                    stall = 1'b1;
                    state_d = WAIT;
                    pend_d = (pend_q == P_NONE) ? req_kind : pend_q;
                end else if (apply != P_NONE) begin
                    sel = 1'b1;
                    rj = (apply == P_REG);
                    fl = 1'b1;
                    pend_d = P_NONE;
                    fcnt_d = FLOAD;
                    state_d = AFTER;
                end else begin
                    stall = HazStall;
                    state_d = RUN;
                end
            end
            FLUSH: begin
                fl = 1'b1;
                stall = ImemStall | HazStall;
                fcnt_d = fcnt_q - 3'd1;
                if (HaltReq) begin
                    hlt = 1'b1;
                    stall = 1'b1;
                    state_d = HALTED;
                end else if (fcnt_q == 3'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                hlt = 1'b1;
                stall = 1'b1;
            end
        endcase
    end
    // outputs are forced low for as long as reset is held
    always_comb begin
        PcStall = !rst && stall;
        PCSel = !rst && sel;
        RegJmp = !rst && rj;
        Halt = !rst && hlt;
        Flush = !rst && fl;
        FetchEn = !rst && (state_q != HALTED);
        StallCnt = cnt_q;
    end
    // control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pend_q <= P_NONE;
            fcnt_q <= 3'd0;
        end else begin
            state_q <= state_d;
            pend_q <= pend_d;
            fcnt_q <= fcnt_d;
        end
    end
    // saturating count of stalled cycles, frozen once halted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (stall && state_q != HALTED && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
endmodule
